alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one 4-bit `alu` instance among four requesters. Each requester presents an operand pair and a 3-bit opcode through a valid/ready handshake. The block latches the granted request, drives the ALU for one cycle and captures `result`/`carry`/`zero`/`negative` into a response register. It returns the response on a shared, tagged response channel with backpressure. The block sits between requester logic and the `alu` datapath, which is instantiated outside this block.

## Interface
- No parameters; requester count fixed at 4, ALU widths fixed (4-bit operands, 3-bit sel, 5-bit result).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  4  per-requester request valid
- req_ready  out  4  per-requester accept, one-hot or zero
- req_a  in  16  packed operand A, requester i at [4i+3:4i]
- req_b  in  16  packed operand B, same packing
- req_sel  in  12  packed opcode, requester i at [3i+2:3i]
- alu_a  out  4  to alu.a
- alu_b  out  4  to alu.b
- alu_sel  out  3  to alu.sel
- alu_result  in  5  from alu.result
- alu_carry, alu_zero, alu_negative  in  1 each  from alu flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  2  index of requester owning the response
- rsp_result  out  5  captured ALU result
- rsp_carry, rsp_zero, rsp_negative  out  1 each  captured flags
- ops_done  out  16  count of completed response handshakes

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Round-robin pick among set `req_valid` bits, searching ptr, ptr+1, … mod 4.
  - `req_ready` is combinational: the one-hot grant while in IDLE with rst_n high, else 0.
  - On accept: latch a/b/sel of the winner into the operand registers and the winner index into tag; set ptr <= winner+1 mod 4; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - `alu_a`/`alu_b`/`alu_sel` are driven from the operand registers; these registers drive the ALU ports in every state.
  - At the end of the cycle, capture the `alu_*` inputs into the `rsp_*` registers, set `rsp_id` <= tag, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_*` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_valid`&`rsp_ready`: `ops_done` += 1, wrapping 0xFFFF->0; go to IDLE.
- Opcode semantics belong entirely to `alu`; this block never decodes sel.
- Requesters must hold their valid/payload until ready. The block never accepts while EXEC or RESP.
- Reset values: state IDLE, ptr 0, tag 0, `alu_a`/`alu_b`/`alu_sel` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, all flags 0, `ops_done` 0. `req_ready` is 0 while rst_n is low.
- Reset mid-operation (EXEC or RESP): the transaction is dropped and all state returns to reset values on that edge. No response is issued.

## Timing
- Request accepted in cycle c (valid&ready high).
- ALU ports show the operands in cycle c+1.
- `rsp_valid` is high from cycle c+2.
- The earliest next accept is the cycle after the response handshake, giving a minimum period of 3 cycles per operation.
- `rsp_ready` may be high before `rsp_valid`; the handshake completes in the first RESP cycle.
- A request that arrives while busy waits and is granted in the first IDLE cycle, subject to round-robin.
- A single valid requester is granted regardless of ptr.
- `alu_*` outputs hold their last operands in IDLE and RESP; there are no glitches from unchosen requesters.

## Test plan
- **Reset:** rst_n=0 for 3 cycles with `req_valid`=4'b1111 -> `req_ready`=0, `rsp_valid`=0, `alu_a`/`alu_b`/`alu_sel`=0, `ops_done`=0.
- **Single op:** requester 0 with a=4'b1010, b=4'b0110, sel=3'b000, `rsp_ready`=1.
  - `req_ready`=4'b0001 in cycle c.
  - `alu_a`=1010, `alu_b`=0110, `alu_sel`=000 in cycle c+1.
  - `rsp_valid`=1 with `rsp_id`=0 in cycle c+2; payload equals the `alu` outputs for those operands.
  - `ops_done`=1 afterwards.
- **Fairness:** all four requesters continuously valid, `rsp_ready`=1 -> grant order 0,1,2,3,0, one grant every 3 cycles, `rsp_id` sequence matching.
- **Skip/wrap:** after a grant to requester 1 (ptr=2), `req_valid`=4'b0011 -> requester 0 is granted next (search 2,3,0), then requester 1.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP, with a=4'b1010, b=4'b1010, sel=3'b111.
  - `rsp_valid` and payload stay stable; `req_ready`=0 throughout.
  - After `rsp_ready`=1, a grant appears in the following cycle.
- **Reset mid-op:** rst_n=0 for one edge while in RESP -> `rsp_valid`=0 and ptr=0 next cycle, no response for the dropped op, `ops_done` cleared.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter and sequencer sharing one external 4-bit ALU among
//   four requesters. A granted request is latched, presented to the ALU for
//   one cycle, and the ALU outputs are captured into a tagged response
//   register that is held until the consumer accepts it.
//
// Ports
//   clk, rst_n                    clock; synchronous active-low reset
//   req_valid[3:0] / req_ready    per-requester handshake (ready one-hot or 0)
//   req_a[15:0], req_b[15:0]      packed 4-bit operands, requester i at [4i+3:4i]
//   req_sel[11:0]                 packed 3-bit opcodes, requester i at [3i+2:3i]
//   alu_a, alu_b, alu_sel         operand registers driving the external ALU
//   alu_result, alu_carry,
//   alu_zero, alu_negative        external ALU outputs
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_result, rsp_carry,
//   rsp_zero, rsp_negative        captured response payload and owner tag
//   ops_done[15:0]                wrapping count of completed responses
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [11:0] req_sel,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [4:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_negative,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [4:0]  rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_negative,
  output logic [15:0] ops_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  tag_q, tag_d;
  logic [3:0]  op_a_q, op_a_d;
  logic [3:0]  op_b_q, op_b_d;
  logic [2:0]  op_sel_q, op_sel_d;
  logic [1:0]  rsp_id_q, rsp_id_d;
  logic [4:0]  rsp_result_q, rsp_result_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_negative_q, rsp_negative_d;
  logic [15:0] ops_done_q, ops_done_d;

  logic        grant_found;
  logic [1:0]  grant_idx;

  // Search ptr, ptr+1, ... wrapping mod 4; the first valid requester wins.
  always_comb begin
    logic [1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && grant_found) begin
      req_ready = 4'b0001 << grant_idx;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    tag_d          = tag_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_sel_d       = op_sel_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_negative_d = rsp_negative_q;
    ops_done_d     = ops_done_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (grant_idx == 2'(i)) begin
              op_a_d   = req_a[4*i +: 4];
              op_b_d   = req_b[4*i +: 4];
              op_sel_d = req_sel[3*i +: 3];
            end
          end
          tag_d   = grant_idx;
          ptr_d   = grant_idx + 2'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d   = alu_result;
        rsp_carry_d    = alu_carry;
        rsp_zero_d     = alu_zero;
        rsp_negative_d = alu_negative;
        rsp_id_d       = tag_q;
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      tag_q          <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_sel_q       <= '0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_negative_q <= 1'b0;
      ops_done_q     <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      tag_q          <= tag_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_sel_q       <= op_sel_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_negative_q <= rsp_negative_d;
      ops_done_q     <= ops_done_d;
    end
  end

  assign alu_a        = op_a_q;
  assign alu_b        = op_b_q;
  assign alu_sel      = op_sel_q;
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_negative = rsp_negative_q;
  assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter. Provides a behavioural stand-in for the external
//   ALU, directed scenarios with literal expectations, and a randomized phase
//   checked every cycle against a transaction-level model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [11:0] req_sel;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [4:0]  alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_negative;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_negative;
  logic [15:0] ops_done;

  int total = 0;
  int bad   = 0;

  alu_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sel      (req_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .ops_done     (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {negative, zero, carry, result[4:0]}.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s);
    logic [4:0] r;
    case (s)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {a, 1'b0};
      3'd6:    r = {2'b00, a[3:1]};
      default: r = {1'b0, ~a};
    endcase
    return {r[3], (r[3:0] == 4'd0), r[4], r};
  endfunction

  always_comb begin
    {alu_negative, alu_zero, alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_sel);
  end

  // Transaction-level model: one in-flight operation, described by how many
  // cycles have passed since it was accepted.
  int         m_ptr = 0;
  bit         m_busy = 0;
  int         m_age = 0;
  int         m_w = -1;
  logic [3:0] m_a = '0;
  logic [3:0] m_b = '0;
  logic [2:0] m_sel = '0;
  int         m_tag = 0;
  logic [1:0] m_id = '0;
  logic [4:0] m_res = '0;
  logic       m_c = 0, m_z = 0, m_n = 0;
  int         m_ops = 0;
  logic [3:0] m_acc = '0;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model; called once per cycle.
  task automatic eval_cycle();
    logic [3:0] exp_ready;
    #1;
    m_w = rr_pick(req_valid, m_ptr);
    exp_ready = '0;
    if (rst_n && !m_busy && m_w >= 0) exp_ready = 4'b0001 << m_w;
    chk("m_req_ready", req_ready, exp_ready);
    chk("m_alu_a", alu_a, m_a);
    chk("m_alu_b", alu_b, m_b);
    chk("m_alu_sel", alu_sel, m_sel);
    chk("m_rsp_valid", rsp_valid, (m_busy && m_age >= 2));
    chk("m_rsp_id", rsp_id, m_id);
    chk("m_rsp_result", rsp_result, m_res);
    chk("m_rsp_carry", rsp_carry, m_c);
    chk("m_rsp_zero", rsp_zero, m_z);
    chk("m_rsp_negative", rsp_negative, m_n);
    chk("m_ops_done", ops_done, 32'(m_ops));
  endtask

  task automatic advance();
    @(posedge clk);
    m_acc = '0;
    if (!rst_n) begin
      m_ptr = 0; m_busy = 0; m_age = 0; m_tag = 0;
      m_a = '0; m_b = '0; m_sel = '0;
      m_id = '0; m_res = '0; m_c = 0; m_z = 0; m_n = 0; m_ops = 0;
    end else if (!m_busy) begin
      if (m_w >= 0) begin
        m_a   = req_a[4*m_w +: 4];
        m_b   = req_b[4*m_w +: 4];
        m_sel = req_sel[3*m_w +: 3];
        m_tag = m_w;
        m_ptr = (m_w + 1) % 4;
        m_busy = 1;
        m_age = 1;
        m_acc = 4'b0001 << m_w;
      end
    end else if (m_age == 1) begin
      {m_n, m_z, m_c, m_res} = alu_fn(m_a, m_b, m_sel);
      m_id  = 2'(m_tag);
      m_age = 2;
    end else if (rsp_ready) begin
      m_ops  = (m_ops + 1) % 65536;
      m_busy = 0;
      m_age  = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] s);
    req_a[4*i +: 4]   = a;
    req_b[4*i +: 4]   = b;
    req_sel[3*i +: 3] = s;
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
    end
  endtask

  // One full 3-cycle operation with rsp_ready held high.
  task automatic op_cycle(input logic [3:0] g, input logic [1:0] id);
    eval_cycle();
    chk("grant", req_ready, g);
    advance();
    eval_cycle();
    chk("exec_no_grant", req_ready, 4'b0000);
    advance();
    eval_cycle();
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, id);
    advance();
  endtask

  logic [3:0] pend;

  initial begin
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_sel = '0;
    @(negedge clk);
    advance();

    // Reset held with every requester asserting valid.
    for (int c = 0; c < 3; c++) begin
      eval_cycle();
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_alu_a", alu_a, 4'd0);
      chk("rst_alu_b", alu_b, 4'd0);
      chk("rst_alu_sel", alu_sel, 3'd0);
      chk("rst_ops_done", ops_done, 16'd0);
      advance();
    end

    // Fairness, then skip/wrap from ptr=2 with only requesters 0 and 1 valid.
    rst_n = 1'b1;
    rand_payloads();
    op_cycle(4'b0001, 2'd0);
    op_cycle(4'b0010, 2'd1);
    op_cycle(4'b0100, 2'd2);
    op_cycle(4'b1000, 2'd3);
    op_cycle(4'b0001, 2'd0);
    op_cycle(4'b0010, 2'd1);
    req_valid = 4'b0011;
    op_cycle(4'b0001, 2'd0);
    op_cycle(4'b0010, 2'd1);

    // Single op: 1010 + 0110 = 1_0000.
    req_valid = 4'b0001;
    set_req(0, 4'b1010, 4'b0110, 3'b000);
    eval_cycle();
    chk("single_grant", req_ready, 4'b0001);
    advance();
    req_valid = 4'b0000;
    eval_cycle();
    chk("single_alu_a", alu_a, 4'b1010);
    chk("single_alu_b", alu_b, 4'b0110);
    chk("single_alu_sel", alu_sel, 3'b000);
    advance();
    eval_cycle();
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_rsp_id", rsp_id, 2'd0);
    chk("single_result", rsp_result, 5'h10);
    chk("single_carry", rsp_carry, 1'b1);
    chk("single_zero", rsp_zero, 1'b1);
    chk("single_negative", rsp_negative, 1'b0);
    advance();
    eval_cycle();
    chk("single_ops_done", ops_done, 16'd9);

    // Backpressure: ~1010 = 0_0101 held for 5 stalled RESP cycles.
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    set_req(0, 4'b1010, 4'b1010, 3'b111);
    eval_cycle();
    chk("bp_grant", req_ready, 4'b0001);
    advance();
    req_valid = 4'b1110;
    eval_cycle();
    advance();
    for (int c = 0; c < 5; c++) begin
      eval_cycle();
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_result", rsp_result, 5'h05);
      chk("bp_flags", {rsp_negative, rsp_zero, rsp_carry}, 3'b000);
      chk("bp_req_ready", req_ready, 4'b0000);
      advance();
    end
    rsp_ready = 1'b1;
    eval_cycle();
    chk("bp_release_valid", rsp_valid, 1'b1);
    advance();
    eval_cycle();
    chk("bp_next_grant", req_ready, 4'b0010);
    chk("bp_ops_done", ops_done, 16'd10);
    advance();
    req_valid = 4'b0000;
    eval_cycle();
    advance();
    eval_cycle();
    advance();

    // Reset while a response is pending.
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    eval_cycle();
    chk("mid_grant", req_ready, 4'b0100);
    advance();
    req_valid = 4'b0000;
    eval_cycle();
    advance();
    eval_cycle();
    chk("mid_rsp_valid_before", rsp_valid, 1'b1);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    eval_cycle();
    chk("mid_ready_in_reset", req_ready, 4'b0000);
    advance();
    rst_n = 1'b1;
    eval_cycle();
    chk("mid_rsp_valid_after", rsp_valid, 1'b0);
    chk("mid_ops_done", ops_done, 16'd0);
    chk("mid_ptr_zero", req_ready, 4'b0001);
    rsp_ready = 1'b1;
    advance();

    // Randomized traffic; requesters hold valid/payload until accepted.
    pend = req_valid & ~m_acc;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
        end
      end
      req_valid = pend;
      rsp_ready = 1'($urandom_range(0, 1));
      rst_n     = ($urandom_range(0, 199) != 0);
      eval_cycle();
      advance();
      pend = pend & ~m_acc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
